inv_mixcol_sequencer: RTL and testbench
=======================================

// Module: inv_mixcol_sequencer
// PURPOSE
//  Column-serial controller for the decryption round's InvMixColumns step. Shares one
//  MixColumnHelper instance (32-bit combinational: 0e/0b/0d/09 matrix over 1 column)
//  across the 4 columns of a 128-bit state. Sits between InvSubBytes/AddRoundKey and
//  the round register. Valid/ready on both sides; per-block bypass for final round.
// PARAMETERS
//  PIPE_HELPER  0  1 = register helper output before write-back (+1 cycle/column, timing)
// PORTS
//  clk        in   1    clock; all logic on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    input block offered
//  in_ready   out  1    controller can accept a block
//  in_state   in   128  state; col0=[127:96], col1=[95:64], col2=[63:32], col3=[31:0]
//  in_bypass  in   1    sampled with block; 1 = pass state through unchanged
//  out_valid  out  1    out_state holds a finished block
//  out_ready  in   1    downstream accepts out_state
//  out_state  out  128  result, same column packing as in_state
//  busy       out  1    high in any state but IDLE
// BEHAVIOUR
//  - One clock, clk. Reset is synchronous and active-high (rst).
//  - Reset: FSM=IDLE, col counter=0, out_valid=0, out_state=0, shadow regs=0.
//  - in_ready = (fsm==IDLE) & ~rst (combinational). busy = (fsm!=IDLE).
//  - Accept = in_valid & in_ready. On accept, latch in_state and in_bypass into shadow
//    regs; in_state is ignored after the accept edge.
//  - FSM states:
//    IDLE: on accept -> DONE if in_bypass, else RUN (col=0).
//    RUN: col k (0..3) drives helper input; helper result written to out_state column k
//      (PIPE_HELPER=0: same edge; =1: one edge later via pipe reg). Other columns of
//      out_state are not modified. After the col-3 write -> DONE.
//    DONE: out_valid=1. On out_ready -> IDLE, out_valid=0 next edge.
//  - Bypass: out_state <= shadow state on the edge entering DONE.
//  - Latency (accept edge to first edge with out_valid=1): bypass 1; PIPE_HELPER=0: 5;
//    PIPE_HELPER=1: 6. No overlap; next accept is no earlier than the edge after the
//    out_valid&out_ready edge.
//  - Backpressure: in DONE with out_ready=0, out_valid and out_state hold indefinitely.
//  - out_ready ignored outside DONE. in_valid ignored outside IDLE.
//  - Column counter is 2 bits. It resets to 0 on entering RUN and is never advanced
//    past 3.
//  - Reset mid-RUN/DONE aborts: block discarded, all regs return to reset values.
//  - Helper is purely combinational. No arithmetic beyond XOR inside the helper.
// TESTING
//  1 in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, bypass=0 ->
//    out_state=db135345_f20a225c_01010101_c6c6c6c6; out_valid 5 edges after accept.
//  2 same in_state, bypass=1 -> out_state equals in_state, out_valid 1 edge after
//    accept; helper output unused.
//  3 out_ready=0 for 10 cycles in DONE -> out_valid=1, out_state stable,
//    in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
//  4 rst=1 for 1 cycle while col=2 in RUN -> next edge IDLE, out_valid=0,
//    out_state=0, busy=0; in_ready=1 once rst=0.
//  5 in_valid held high, two blocks (4d7ebdf8 x4 then 0 x4), in_state changed after
//    accept -> outputs 2d26314c x4 then 0 x4; 2nd accept only after 1st handshake.
//  6 PIPE_HELPER=1, vector of test 1 -> same out_state, out_valid 6 edges after accept.

Source files
------------

// File: rtl/inv_mixcol_if.sv
// Handshake bundle between the decryption round datapath and the InvMixColumns sequencer.
// Upstream/downstream logic uses the master side; the sequencer uses the slave side.
interface inv_mixcol_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/inv_mixcol_sequencer.sv
// Column-serial InvMixColumns controller: one shared 32-bit helper is time-multiplexed
// over the four state columns, with a per-block bypass for the final round.
module inv_mixcol_sequencer #(
  parameter int PIPE_HELPER = 0
) (
  input  logic          clk,
  input  logic          rst,
  inv_mixcol_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [127:0]  shadow_q, shadow_d;
  logic          bypass_q, bypass_d;
  logic [127:0]  out_state_q, out_state_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   pipe_q, pipe_d;
  logic [1:0]    pcol_q, pcol_d;
  logic          pvld_q, pvld_d;

  logic          accept;
  logic [31:0]   helper_in, helper_out;
  logic          wr_en;
  logic [1:0]    wr_col;
  logic [31:0]   wr_data;
  logic          last_wr;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Byte 0 of a column is its most significant byte (top row of the state matrix).
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3),
            m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3),
            m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3),
            m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3)};
  endfunction

  function automatic logic [31:0] col_sel(input logic [127:0] s, input logic [1:0] k);
    case (k)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      shadow_q    <= '0;
      bypass_q    <= 1'b0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      pipe_q      <= '0;
      pcol_q      <= 2'd0;
      pvld_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      shadow_q    <= shadow_d;
      bypass_q    <= bypass_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      pipe_q      <= pipe_d;
      pcol_q      <= pcol_d;
      pvld_q      <= pvld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = bus.in_bypass ? DONE : RUN;
      RUN:     if (last_wr) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) & ~rst;
    bus.busy      = (state_q != IDLE);
    bus.out_valid = out_valid_q;
    bus.out_state = out_state_q;
    accept        = bus.in_valid & bus.in_ready;

    helper_in  = col_sel(shadow_q, col_q);
    helper_out = inv_mix(helper_in);

    // With the pipe register, writes trail the helper by one edge and carry their column tag.
    if (PIPE_HELPER != 0) begin
      wr_en   = pvld_q;
      wr_col  = pcol_q;
      wr_data = pipe_q;
    end else begin
      wr_en   = (state_q == RUN);
      wr_col  = col_q;
      wr_data = helper_out;
    end
    last_wr = wr_en & (wr_col == 2'd3);

    shadow_d = shadow_q;
    bypass_d = bypass_q;
    if (accept) begin
      shadow_d = bus.in_state;
      bypass_d = bus.in_bypass;
    end

    col_d = col_q;
    if (state_q == IDLE && accept)
      col_d = 2'd0;
    else if (state_q == RUN && col_q != 2'd3)
      col_d = col_q + 2'd1;

    pipe_d = helper_out;
    pcol_d = col_q;
    pvld_d = (state_q == RUN) & ~last_wr;

    out_state_d = out_state_q;
    if (wr_en) begin
      case (wr_col)
        2'd0:    out_state_d[127:96] = wr_data;
        2'd1:    out_state_d[95:64]  = wr_data;
        2'd2:    out_state_d[63:32]  = wr_data;
        default: out_state_d[31:0]   = wr_data;
      endcase
    end
    if (state_q == IDLE && accept && bus.in_bypass)
      out_state_d = bus.in_state;

    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_inv_mixcol_sequencer.sv
// Scoreboard bench for inv_mixcol_sequencer: directed blocks on a PIPE_HELPER=0 and a
// PIPE_HELPER=1 instance, with expected results queued at accept and checked by a monitor.
module tb_inv_mixcol_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  inv_mixcol_if bus0();
  inv_mixcol_if bus1();

  inv_mixcol_sequencer #(.PIPE_HELPER(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  inv_mixcol_sequencer #(.PIPE_HELPER(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [127:0] st;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic         pv[2];
  logic [127:0] ps[2];

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] VA = {4{32'h4d7ebdf8}};
  localparam logic [127:0] RA = {4{32'h2d26314c}};

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got cycle %0d expected cycle %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int sel, input logic v, input logic r,
                     input logic [127:0] s, input logic ir);
    exp_t e;
    int   n;
    if (rst) begin
      pv[sel] = 1'b0;
      return;
    end
    n = (sel != 0) ? q1.size() : q0.size();
    if (v) begin
      chk1($sformatf("in_ready_while_done_dut%0d", sel), ir, 1'b0);
      if (!pv[sel]) begin
        if (n == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out_dut%0d: out_valid=1 expected 0", sel);
        end else begin
          e = (sel != 0) ? q1[0] : q0[0];
          chkint($sformatf("latency_dut%0d", sel), cyc, e.acc + e.lat - 1);
        end
      end else begin
        chk128($sformatf("hold_stable_dut%0d", sel), s, ps[sel]);
      end
      if (r && n != 0) begin
        e = (sel != 0) ? q1.pop_front() : q0.pop_front();
        chk128($sformatf("out_state_dut%0d", sel), s, e.st);
      end
    end
    pv[sel] = v;
    ps[sel] = s;
  endtask

  always @(negedge clk) begin
    #2;
    mon(0, bus0.out_valid, bus0.out_ready, bus0.out_state, bus0.in_ready);
    mon(1, bus1.out_valid, bus1.out_ready, bus1.out_state, bus1.in_ready);
  end

  task automatic drive(input int sel, input logic v, input logic [127:0] st, input logic byp);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.in_state = st; bus0.in_bypass = byp;
    end else begin
      bus1.in_valid = v; bus1.in_state = st; bus1.in_bypass = byp;
    end
  endtask

  // Called at a falling edge; returns at the falling edge just after the accept edge.
  task automatic send(input int sel, input logic [127:0] st, input logic byp,
                      input logic [127:0] exp, input int lat, input logic keep);
    exp_t e;
    int   n;
    n = 0;
    drive(sel, 1'b1, st, byp);
    while (!((sel != 0) ? bus1.in_ready : bus0.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout_dut%0d: in_ready=0 expected 1", sel);
      drive(sel, 1'b0, st, byp);
      return;
    end
    e.st = exp; e.acc = cyc + 1; e.lat = lat;
    if (sel != 0) q1.push_back(e); else q0.push_back(e);
    @(negedge clk);
    drive(sel, keep, ~st, ~byp);
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while ((q0.size() != 0 || !bus0.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: in_ready=%b expected 1", bus0.in_ready);
    end
  endtask

  initial begin
    int n;
    pv[0] = 1'b0; pv[1] = 1'b0;
    ps[0] = '0;   ps[1] = '0;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_out_valid", bus0.out_valid, 1'b0);
    chk128("rst_out_state", bus0.out_state, '0);
    chk1("rst_busy", bus0.busy, 1'b0);
    chk1("rst_in_ready_during_rst", bus0.in_ready, 1'b0);
    chk1("rst_out_valid_dut1", bus1.out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk1("in_ready_after_rst", bus0.in_ready, 1'b1);
    @(negedge clk);

    // Normal block, then bypass block
    send(0, V1, 1'b0, R1, 5, 1'b0);
    send(0, V1, 1'b1, V1, 1, 1'b0);

    // Backpressure held for ten cycles in DONE
    wait_idle0();
    bus0.out_ready = 1'b0;
    send(0, V1, 1'b0, R1, 5, 1'b0);
    n = 0;
    while (!bus0.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk1("bp_out_valid", bus0.out_valid, 1'b1);
      chk128("bp_out_state", bus0.out_state, R1);
      chk1("bp_in_ready", bus0.in_ready, 1'b0);
      @(negedge clk);
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk1("bp_release_in_ready", bus0.in_ready, 1'b1);
    chk1("bp_release_busy", bus0.busy, 1'b0);
    chk1("bp_release_out_valid", bus0.out_valid, 1'b0);

    // Reset while column 2 is in flight
    wait_idle0();
    send(0, V1, 1'b0, R1, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q0.delete();
    @(negedge clk);
    chk1("abort_out_valid", bus0.out_valid, 1'b0);
    chk128("abort_out_state", bus0.out_state, '0);
    chk1("abort_busy", bus0.busy, 1'b0);
    rst = 1'b0;
    #1;
    chk1("abort_in_ready", bus0.in_ready, 1'b1);
    @(negedge clk);

    // Back-to-back blocks with in_valid held high
    send(0, VA, 1'b0, RA, 5, 1'b1);
    send(0, '0, 1'b0, '0, 5, 1'b0);

    // Registered-helper instance: normal then bypass
    send(1, V1, 1'b0, R1, 6, 1'b0);
    send(1, V1, 1'b1, V1, 1, 1'b0);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q0.size() + q1.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
